// File: rtl/pe_pkg.sv
// Shared definitions for the PE row: op encoding, sequencer states,
// Horner term counts and the Q5.10 unary-op coefficient tables.
package pe_pkg;

  typedef enum logic [1:0] {
    OP_GEMM = 2'b00,
    OP_DIV  = 2'b01,
    OP_EXP  = 2'b10,
    OP_LOG  = 2'b11
  } op_e;

  typedef enum logic [2:0] {
    S_IDLE,
    S_G_RUN,
    S_G_DRAIN,
    S_U_FETCH,
    S_U_ITER,
    S_U_WB,
    S_DONE
  } state_e;

  localparam int N_TERM_DIV = 4;
  localparam int N_TERM_EXP = 4;
  localparam int N_TERM_LOG = 4;
  localparam int N_TERM_MAX = 4;
  localparam int ITER_W     = $clog2(N_TERM_MAX);

  localparam int Q_W = 16;
  typedef logic signed [Q_W-1:0] coef_t;

  // Tables are indexed by Horner term k; k = N_TERM-1 is applied first.
  // div: 1/(1+x) ~ 1 - x + x^2 - x^3
  localparam coef_t COEF_DIV [N_TERM_MAX] = '{16'sh0400, 16'shFC00, 16'sh0400, 16'shFC00};
  // exp: 1 + x + x^2/2 + x^3/6
  localparam coef_t COEF_EXP [N_TERM_MAX] = '{16'sh0400, 16'sh0400, 16'sh0200, 16'sh00AB};
  // log: ln(1+x) ~ x - x^2/2 + x^3/3
  localparam coef_t COEF_LOG [N_TERM_MAX] = '{16'sh0000, 16'sh0400, 16'shFE00, 16'sh0155};

  function automatic int n_term(op_e op);
    case (op)
      OP_DIV:  return N_TERM_DIV;
      OP_EXP:  return N_TERM_EXP;
      OP_LOG:  return N_TERM_LOG;
      default: return 0;
    endcase
  endfunction

endpackage

// File: rtl/pe_coef_rom.sv
// Combinational (op, k) -> Horner coefficient lookup.
module pe_coef_rom
  import pe_pkg::*;
(
  input  op_e               op_i,
  input  logic [ITER_W-1:0] k_i,
  output coef_t             coef_o
);

  always_comb begin
    coef_o = '0;
    case (op_i)
      OP_DIV:  coef_o = COEF_DIV[k_i];
      OP_EXP:  coef_o = COEF_EXP[k_i];
      OP_LOG:  coef_o = COEF_LOG[k_i];
      default: coef_o = '0;
    endcase
  end

endmodule

// File: rtl/pe_seq_ctrl.sv
// Command sequencer for a lockstep row of pe_l elements: GEMM streaming
// plus drain, or per-element Horner evaluation of div/exp/log.
module pe_seq_ctrl
  import pe_pkg::*;
#(
  parameter int ARR_N  = 8,
  parameter int LEN_BW = 8,
  parameter int MUL_BW = 16,
  parameter int INT_BW = 5,
  parameter int FRA_BW = 10
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     cmd_valid,
  output logic                     cmd_ready,
  input  logic [1:0]               cmd_op,
  input  logic [LEN_BW-1:0]        cmd_len,
  output logic [1:0]               gemm_uno,
  output logic                     in_rd_en,
  output logic                     fb_sel,
  output logic signed [MUL_BW-1:0] wc_o,
  output logic                     res_vld,
  output logic                     done,
  output logic                     busy
);

  localparam int DRAIN = 2 * ARR_N - 1;
  localparam int DRN_W = $clog2(DRAIN + 1);

  if (MUL_BW != Q_W || 1 + INT_BW + FRA_BW != MUL_BW) begin : g_fmt_chk
    $error("coefficient tables are Q5.10 in 16 bits; MUL_BW/INT_BW/FRA_BW disagree");
  end

  state_e              state_q;
  op_e                 op_q;
  logic [LEN_BW-1:0]   cnt_q;
  logic [ITER_W-1:0]   iter_q;
  logic [DRN_W-1:0]    drn_q;
  logic [1:0]          gemm_uno_q;
  logic                in_rd_en_q;
  logic                fb_sel_q;
  coef_t               wc_q;
  logic                res_vld_q;
  logic                done_q;

  logic [ITER_W-1:0]   k_d;
  coef_t               coef_d;

  // Term index for the coming U_ITER cycle, looked up one cycle early so wc_o is registered.
  always_comb begin
    k_d = iter_q - 1'b1;
    if (state_q == S_U_FETCH) k_d = ITER_W'(n_term(op_q) - 1);
  end

  pe_coef_rom u_rom (
    .op_i   (op_q),
    .k_i    (k_d),
    .coef_o (coef_d)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      op_q       <= OP_GEMM;
      cnt_q      <= '0;
      iter_q     <= '0;
      drn_q      <= '0;
      gemm_uno_q <= 2'b00;
      in_rd_en_q <= 1'b0;
      fb_sel_q   <= 1'b0;
      wc_q       <= '0;
      res_vld_q  <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (cmd_valid) begin
            op_q       <= op_e'(cmd_op);
            gemm_uno_q <= cmd_op;
            cnt_q      <= cmd_len;
            if (cmd_len == '0) begin
              state_q <= S_DONE;
              done_q  <= 1'b1;
            end else begin
              in_rd_en_q <= 1'b1;
              state_q    <= (op_e'(cmd_op) == OP_GEMM) ? S_G_RUN : S_U_FETCH;
            end
          end
        end
        S_G_RUN: begin
          cnt_q <= cnt_q - 1'b1;
          if (cnt_q == LEN_BW'(1)) begin
            in_rd_en_q <= 1'b0;
            drn_q      <= DRN_W'(DRAIN);
            state_q    <= S_G_DRAIN;
          end
        end
        S_G_DRAIN: begin
          drn_q <= drn_q - 1'b1;
          if (drn_q == DRN_W'(1)) begin
            res_vld_q <= 1'b1;
            done_q    <= 1'b1;
            state_q   <= S_DONE;
          end
        end
        S_U_FETCH: begin
          in_rd_en_q <= 1'b0;
          iter_q     <= k_d;
          fb_sel_q   <= 1'b0;
          wc_q       <= coef_d;
          state_q    <= S_U_ITER;
        end
        S_U_ITER: begin
          if (iter_q == '0) begin
            fb_sel_q <= 1'b0;
            wc_q     <= '0;
            state_q  <= S_U_WB;
          end else begin
            iter_q   <= k_d;
            fb_sel_q <= 1'b1;
            wc_q     <= coef_d;
          end
        end
        // iter_q doubles as the wreg/oreg phase flag here.
        S_U_WB: begin
          if (iter_q == '0) begin
            iter_q    <= ITER_W'(1);
            res_vld_q <= 1'b1;
          end else begin
            iter_q    <= '0;
            res_vld_q <= 1'b0;
            cnt_q     <= cnt_q - 1'b1;
            if (cnt_q == LEN_BW'(1)) begin
              done_q  <= 1'b1;
              state_q <= S_DONE;
            end else begin
              in_rd_en_q <= 1'b1;
              state_q    <= S_U_FETCH;
            end
          end
        end
        S_DONE: begin
          done_q     <= 1'b0;
          res_vld_q  <= 1'b0;
          gemm_uno_q <= 2'b00;
          state_q    <= S_IDLE;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign cmd_ready = (state_q == S_IDLE);
  assign busy      = (state_q != S_IDLE);
  assign gemm_uno  = gemm_uno_q;
  assign in_rd_en  = in_rd_en_q;
  assign fb_sel    = fb_sel_q;
  assign wc_o      = wc_q;
  assign res_vld   = res_vld_q;
  assign done      = done_q;

endmodule

// File: tb/tb_pe_seq_ctrl.sv
// Directed bench for pe_seq_ctrl: per-cycle output checks from a timeline
// model plus a queue of expected res_vld/done events.
module tb_pe_seq_ctrl;

  localparam int ARR_N  = 8;
  localparam int LEN_BW = 8;
  localparam int MUL_BW = 16;

  logic                     clk = 1'b0;
  logic                     rst_n = 1'b0;
  logic                     cmd_valid = 1'b0;
  logic                     cmd_ready;
  logic [1:0]               cmd_op = 2'b00;
  logic [LEN_BW-1:0]        cmd_len = '0;
  logic [1:0]               gemm_uno;
  logic                     in_rd_en;
  logic                     fb_sel;
  logic signed [MUL_BW-1:0] wc_o;
  logic                     res_vld;
  logic                     done;
  logic                     busy;
  logic [MUL_BW-1:0]        wc_u;

  assign wc_u = wc_o;

  int npass = 0;
  int ntot  = 0;
  int nfail = 0;

  typedef struct {
    int kind;  // 0 res_vld, 1 done
    int rel;   // cycle after accept
  } ev_t;
  ev_t sbq[$];

  always #5 clk = ~clk;

  pe_seq_ctrl #(
    .ARR_N(ARR_N), .LEN_BW(LEN_BW), .MUL_BW(MUL_BW), .INT_BW(5), .FRA_BW(10)
  ) dut (
    .clk(clk), .rst_n(rst_n), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_op(cmd_op), .cmd_len(cmd_len), .gemm_uno(gemm_uno), .in_rd_en(in_rd_en),
    .fb_sel(fb_sel), .wc_o(wc_o), .res_vld(res_vld), .done(done), .busy(busy)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    ntot++;
    assert (obs === exp) npass++;
    else begin
      nfail++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [15:0] ref_coef(input logic [1:0] op, input int k);
    logic [3:0] sel;
    sel = {op, 2'(k)};
    case (sel)
      4'b01_11: return 16'hFC00;
      4'b01_10: return 16'h0400;
      4'b01_01: return 16'hFC00;
      4'b01_00: return 16'h0400;
      4'b10_11: return 16'h00AB;
      4'b10_10: return 16'h0200;
      4'b10_01: return 16'h0400;
      4'b10_00: return 16'h0400;
      4'b11_11: return 16'h0155;
      4'b11_10: return 16'hFE00;
      4'b11_01: return 16'h0400;
      4'b11_00: return 16'h0000;
      default:  return 16'h0000;
    endcase
  endfunction

  task automatic check_idle(input string tag);
    chk({tag, ".cmd_ready"}, cmd_ready, 1);
    chk({tag, ".busy"},      busy, 0);
    chk({tag, ".gemm_uno"},  gemm_uno, 0);
    chk({tag, ".in_rd_en"},  in_rd_en, 0);
    chk({tag, ".fb_sel"},    fb_sel, 0);
    chk({tag, ".wc_o"},      wc_u, 0);
    chk({tag, ".res_vld"},   res_vld, 0);
    chk({tag, ".done"},      done, 0);
  endtask

  // Called at a negedge. Issues one command and checks every cycle up to
  // the IDLE cycle after DONE. With hold, cmd_valid stays high and op/len
  // wander while busy, settling on nop/nlen in the DONE cycle.
  task automatic do_cmd(input string tag, input logic [1:0] op, input int len,
                        input bit hold, input logic [1:0] nop, input int nlen);
    int nt, per, total, g, pos;
    logic e_rd, e_fb;
    logic [15:0] e_wc;
    ev_t ev;
    g = 0;
    while (cmd_ready !== 1'b1 && g < 50) begin
      @(negedge clk);
      g++;
    end
    chk({tag, ".ready_at_issue"}, cmd_ready, 1);
    cmd_valid = 1'b1;
    cmd_op    = op;
    cmd_len   = LEN_BW'(len);
    nt  = (op == 2'b00) ? 0 : 4;
    per = 3 + nt;
    if (len == 0)         total = 1;
    else if (op == 2'b00) total = len + 2 * ARR_N;
    else                  total = 1 + len * per;
    if (len != 0) begin
      if (op == 2'b00) begin
        ev.kind = 0; ev.rel = total; sbq.push_back(ev);
      end else begin
        for (int e = 0; e < len; e++) begin
          ev.kind = 0; ev.rel = 1 + e * per + nt + 2; sbq.push_back(ev);
        end
      end
    end
    ev.kind = 1; ev.rel = total; sbq.push_back(ev);
    @(posedge clk);
    for (int rel = 1; rel <= total + 1; rel++) begin
      @(negedge clk);
      e_rd = 1'b0; e_fb = 1'b0; e_wc = 16'h0000;
      if (len != 0 && rel < total) begin
        if (op == 2'b00) e_rd = (rel <= len);
        else begin
          pos  = (rel - 1) % per;
          e_rd = (pos == 0);
          if (pos >= 1 && pos <= nt) begin
            e_wc = ref_coef(op, nt - pos);
            e_fb = (pos > 1);
          end
        end
      end
      chk($sformatf("%s.in_rd_en@%0d", tag, rel), in_rd_en, e_rd);
      chk($sformatf("%s.fb_sel@%0d", tag, rel), fb_sel, e_fb);
      chk($sformatf("%s.wc_o@%0d", tag, rel), wc_u, e_wc);
      chk($sformatf("%s.busy@%0d", tag, rel), busy, (rel <= total));
      chk($sformatf("%s.cmd_ready@%0d", tag, rel), cmd_ready, (rel > total));
      if (rel <= total) chk($sformatf("%s.gemm_uno@%0d", tag, rel), gemm_uno, op);
      while (sbq.size() > 0 && sbq[0].rel < rel) begin
        ev = sbq.pop_front();
        chk($sformatf("%s.missed_event_k%0d", tag, ev.kind), rel, ev.rel);
      end
      if (res_vld === 1'b1) begin
        if (sbq.size() == 0) chk($sformatf("%s.res_vld_extra", tag), rel, 0);
        else begin
          ev = sbq.pop_front();
          chk($sformatf("%s.res_vld_kind@%0d", tag, rel), 0, ev.kind);
          chk($sformatf("%s.res_vld_cycle", tag), rel, ev.rel);
        end
      end
      if (done === 1'b1) begin
        if (sbq.size() == 0) chk($sformatf("%s.done_extra", tag), rel, 0);
        else begin
          ev = sbq.pop_front();
          chk($sformatf("%s.done_kind@%0d", tag, rel), 1, ev.kind);
          chk($sformatf("%s.done_cycle", tag), rel, ev.rel);
        end
      end
      if (hold) begin
        if (rel < total) begin
          cmd_op  = 2'($urandom);
          cmd_len = LEN_BW'($urandom_range(1, 255));
        end else begin
          cmd_op  = nop;
          cmd_len = LEN_BW'(nlen);
        end
      end else if (rel == 1) begin
        cmd_valid = 1'b0;
      end
    end
    chk({tag, ".events_left"}, sbq.size(), 0);
    sbq.delete();
  endtask

  initial begin
    int hits;
    // Reset asserted: outputs at reset values.
    repeat (3) @(negedge clk);
    check_idle("in_reset");
    rst_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check_idle($sformatf("idle%0d", i));
    end

    do_cmd("gemm_k4", 2'b00, 4, 1'b0, 2'b00, 0);
    do_cmd("exp_len2", 2'b10, 2, 1'b0, 2'b00, 0);
    do_cmd("div_len0", 2'b01, 0, 1'b0, 2'b00, 0);
    do_cmd("gemm_len0", 2'b00, 0, 1'b0, 2'b00, 0);
    do_cmd("gemm_k1", 2'b00, 1, 1'b0, 2'b00, 0);

    // cmd_valid held high through a GEMM; pending LOG len 1 taken in IDLE.
    do_cmd("gemm_hold", 2'b00, 3, 1'b1, 2'b11, 1);
    do_cmd("log_after_hold", 2'b11, 1, 1'b0, 2'b00, 0);

    // LOG interrupted by reset inside U_ITER.
    cmd_valid = 1'b1; cmd_op = 2'b11; cmd_len = LEN_BW'(2);
    @(posedge clk);
    @(negedge clk);
    cmd_valid = 1'b0;
    repeat (2) @(negedge clk);
    chk("log_rst.in_iter_busy", busy, 1);
    chk("log_rst.in_iter_fb", fb_sel, 1);
    chk("log_rst.in_iter_wc", wc_u, ref_coef(2'b11, 2));
    rst_n = 1'b0;
    #1;
    check_idle("log_rst.async");
    @(negedge clk);
    rst_n = 1'b1;
    hits = 0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      if (done !== 1'b0 || res_vld !== 1'b0 || busy !== 1'b0) hits++;
    end
    chk("log_rst.quiet_after", hits, 0);
    do_cmd("div_after_rst", 2'b01, 1, 1'b0, 2'b00, 0);
    check_idle("final");

    $display("%0d/%0d checks passed", npass, ntot);
    $finish;
  end

endmodule
